// File: rtl/ctrl_io_fault_monitor.sv
// Dual-rail fault monitor: qualifies per-tile invalid-codeword flags against the
// precharge/evaluate phase, keeps sticky per-tile faults and a windowed alarm.
module ctrl_io_fault_monitor #(
  parameter int NUM_IO = 8,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3,
  parameter int WINDOW = 64
) (
  input  logic              UserCLK,
  input  logic              rst,
  input  logic [NUM_IO-1:0] F_ctrl,
  input  logic              prech2,
  input  logic              clr,
  output logic [NUM_IO-1:0] DR_fault,
  output logic [CNT_W-1:0]  fault_cnt,
  output logic              alarm,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_PENDING = 2'd1,
    ST_ALARM   = 2'd2
  } state_t;

  localparam logic [15:0]    WIN_LAST = 16'(WINDOW - 1);
  localparam logic [CNT_W:0] THRESH_W = (CNT_W + 1)'(THRESH);

  logic [NUM_IO-1:0] f_reg;
  logic              p1;
  logic              p2;
  state_t            state_q;
  state_t            state_d;
  logic [15:0]       timer_q;
  logic [15:0]       timer_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [NUM_IO-1:0] sticky_d;

  logic              valid;
  logic [NUM_IO-1:0] hits;
  logic              fault_event;
  logic [CNT_W:0]    cnt_inc;
  logic [CNT_W-1:0]  cnt_sat;
  logic              reach_thresh;

  // The first evaluate cycle still sees the (0,0) spacer, so two evaluate samples are needed.
  assign valid        = p1 & p2;
  assign hits         = f_reg & {NUM_IO{valid}};
  assign fault_event  = |hits;
  assign cnt_inc      = {1'b0, fault_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat      = cnt_inc[CNT_W] ? fault_cnt : cnt_inc[CNT_W-1:0];
  assign reach_thresh = (cnt_inc >= THRESH_W);

  // NOTE: every variable assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = fault_cnt;
    timer_d  = timer_q;
    sticky_d = DR_fault | hits;

    if (fault_event) begin
      cnt_d   = cnt_sat;
      timer_d = '0;
    end

    unique case (state_q)
      ST_MONITOR: begin
        if (fault_event) state_d = reach_thresh ? ST_ALARM : ST_PENDING;
      end
      ST_PENDING: begin
        if (fault_event) begin
          if (reach_thresh) state_d = ST_ALARM;
        end else if (timer_q == WIN_LAST) begin
          state_d = ST_MONITOR;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_ALARM: begin
        state_d = ST_ALARM;
      end
      default: begin
        state_d = ST_MONITOR;
      end
    endcase

    // Clear wins over any event in the same cycle; the event is dropped entirely.
    if (clr) begin
      state_d  = ST_MONITOR;
      cnt_d    = '0;
      timer_d  = '0;
      sticky_d = '0;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so all registers update together
  // from the values present before the edge.
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      f_reg     <= '0;
      p1        <= 1'b0;
      p2        <= 1'b0;
      state_q   <= ST_MONITOR;
      timer_q   <= '0;
      DR_fault  <= '0;
      fault_cnt <= '0;
      alarm     <= 1'b0;
    end else begin
      f_reg     <= F_ctrl;
      p1        <= prech2;
      p2        <= p1;
      state_q   <= state_d;
      timer_q   <= timer_d;
      DR_fault  <= sticky_d;
      fault_cnt <= cnt_d;
      alarm     <= (state_d == ST_ALARM);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_io_fault_monitor.sv
// Scoreboard bench for ctrl_io_fault_monitor: a default instance and a narrow
// saturating instance, both checked against an edge-level behavioural model.
module tb_ctrl_io_fault_monitor;

  logic       UserCLK;
  logic       rst;
  logic [7:0] F_ctrl;
  logic       prech2;
  logic       clr;

  logic [7:0] DR_fault;
  logic [7:0] fault_cnt;
  logic       alarm;
  logic [1:0] state;

  logic [7:0] sat_dr;
  logic [1:0] sat_cnt;
  logic       sat_alarm;
  logic [1:0] sat_state;

  ctrl_io_fault_monitor #(.NUM_IO(8), .CNT_W(8), .THRESH(3), .WINDOW(64)) dut (
    .UserCLK(UserCLK), .rst(rst), .F_ctrl(F_ctrl), .prech2(prech2), .clr(clr),
    .DR_fault(DR_fault), .fault_cnt(fault_cnt), .alarm(alarm), .state(state)
  );

  ctrl_io_fault_monitor #(.NUM_IO(8), .CNT_W(2), .THRESH(3), .WINDOW(5)) dut_sat (
    .UserCLK(UserCLK), .rst(rst), .F_ctrl(F_ctrl), .prech2(prech2), .clr(clr),
    .DR_fault(sat_dr), .fault_cnt(sat_cnt), .alarm(sat_alarm), .state(sat_state)
  );

  initial begin
    UserCLK = 1'b0;
    forever #5 UserCLK = ~UserCLK;
  end

  // Reference model: mode 0 monitor, 1 pending, 2 alarm; timeout measured in edges since last event.
  typedef struct {
    int         cnt;
    logic [7:0] sticky;
    int         mode;
    int         last_ev;
    int         edge_no;
  } model_t;

  typedef struct {
    model_t a;
    model_t b;
  } exp_t;

  model_t     ma;
  model_t     mb;
  exp_t       sb_q[$];
  logic       hist_p0;
  logic       hist_p1;
  logic [7:0] hist_f;

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic model_t model_edge(input model_t m, input bit qual, input logic [7:0] f,
                                        input bit c, input int thresh, input int cmax,
                                        input int window);
    model_t r;
    r = m;
    r.edge_no = m.edge_no + 1;
    if (c) begin
      r.cnt    = 0;
      r.sticky = '0;
      r.mode   = 0;
    end else if (qual && (f != 8'h00)) begin
      r.sticky  = m.sticky | f;
      if (m.mode != 2) r.mode = (m.cnt + 1 >= thresh) ? 2 : 1;
      r.cnt     = (m.cnt + 1 > cmax) ? cmax : m.cnt + 1;
      r.last_ev = r.edge_no;
    end else if (m.mode == 1 && (r.edge_no - m.last_ev) == window) begin
      r.mode = 0;
      r.cnt  = 0;
    end
    return r;
  endfunction

  task automatic model_reset();
    ma      = '{default: 0};
    mb      = '{default: 0};
    hist_p0 = 1'b0;
    hist_p1 = 1'b0;
    hist_f  = '0;
  endtask

  // Drive one sample, let the edge happen, record the expected post-edge outputs.
  task automatic step(input logic [7:0] f, input logic p, input logic c);
    bit qual;
    exp_t e;
    F_ctrl = f;
    prech2 = p;
    clr    = c;
    @(posedge UserCLK);
    qual = hist_p0 && hist_p1;
    ma = model_edge(ma, qual, hist_f, c, 3, 255, 64);
    mb = model_edge(mb, qual, hist_f, c, 3, 3, 5);
    hist_p1 = hist_p0;
    hist_p0 = p;
    hist_f  = f;
    e.a = ma;
    e.b = mb;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic qual_event(input logic [7:0] bits);
    step(8'h00, 1'b1, 1'b0);
    step(bits,  1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1;
    check("rst_dr", DR_fault, 0);
    check("rst_cnt", fault_cnt, 0);
    check("rst_state", state, 0);
    check("rst_alarm", alarm, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_sat_alarm", sat_alarm, 0);
    sb_q.delete();
    model_reset();
    #1 rst = 1'b1;
  endtask

  // Monitor: compares every cycle's registered outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge UserCLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_dr", DR_fault, e.a.sticky);
        check("sb_cnt", fault_cnt, e.a.cnt);
        check("sb_state", state, e.a.mode);
        check("sb_alarm", alarm, (e.a.mode == 2));
        check("sb_sat_dr", sat_dr, e.b.sticky);
        check("sb_sat_cnt", sat_cnt, e.b.cnt);
        check("sb_sat_state", sat_state, e.b.mode);
        check("sb_sat_alarm", sat_alarm, (e.b.mode == 2));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    F_ctrl   = '0;
    prech2   = 1'b0;
    clr      = 1'b0;
    model_reset();
    repeat (2) @(posedge UserCLK);
    #2 rst = 1'b1;

    // Precharge only: flags must never qualify.
    repeat (10) step(8'hFF, 1'b0, 1'b0);
    check("gate_dr", DR_fault, 0);
    check("gate_cnt", fault_cnt, 0);
    check("gate_state", state, 0);
    check("gate_alarm", alarm, 0);

    // A single evaluate cycle is discarded.
    step(8'h01, 1'b1, 1'b0);
    repeat (3) step(8'h00, 1'b0, 1'b0);
    check("discard_dr", DR_fault, 0);
    check("discard_cnt", fault_cnt, 0);

    // Two evaluate cycles: event counted, then window expiry exactly 64 edges later.
    step(8'h01, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("eval2_dr", DR_fault, 8'h01);
    check("eval2_cnt", fault_cnt, 1);
    check("eval2_state", state, 1);
    repeat (63) step(8'h00, 1'b0, 1'b0);
    check("win_before_state", state, 1);
    check("win_before_cnt", fault_cnt, 1);
    step(8'h00, 1'b0, 1'b0);
    check("win_expire_state", state, 0);
    check("win_expire_cnt", fault_cnt, 0);
    check("win_keep_dr", DR_fault, 8'h01);

    // Threshold: three isolated events on bits 0, 3, 7.
    qual_event(8'h01);
    qual_event(8'h08);
    check("thr_pre_alarm", alarm, 0);
    qual_event(8'h80);
    check("thr_dr", DR_fault, 8'h89);
    check("thr_cnt", fault_cnt, 3);
    check("thr_alarm", alarm, 1);
    check("thr_state", state, 2);

    // Clear in the same cycle as a qualified event on bit 2.
    step(8'h00, 1'b1, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    check("clr_state", state, 0);
    check("clr_dr", DR_fault, 0);
    check("clr_cnt", fault_cnt, 0);
    check("clr_alarm", alarm, 0);

    // Event landing on the timeout edge wins over the timeout.
    qual_event(8'h10);
    repeat (61) step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("tie_state", state, 1);
    check("tie_cnt", fault_cnt, 2);
    check("tie_dr", DR_fault, 8'h12);

    // Saturation: six back-to-back events on the 2-bit counter.
    step(8'h00, 1'b0, 1'b1);
    repeat (7) step(8'h20, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("sat_cnt", sat_cnt, 3);
    check("sat_alarm", sat_alarm, 1);
    check("wide_cnt", fault_cnt, 6);

    // Asynchronous reset between edges.
    pulse_reset();

    // Randomized phase, flags and occasional clear.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] f;
      logic       p;
      logic       c;
      p = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      c = ($urandom_range(0, 199) == 0);
      step(f, p, c);
      if (i == 1000) pulse_reset();
    end

    step(8'h00, 1'b0, 1'b0);
    @(negedge UserCLK);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_io_fault_monitor.md
# ctrl_io_fault_monitor

Dual-rail fault monitor downstream of the IO-tile dual-rail checkers. It collects the per-tile `F_ctrl` invalid-codeword flags and qualifies them against the precharge/evaluate phase (`prech2`). Qualified flags are latched into sticky per-IO fault bits and counted inside a sliding time window. When the count reaches a threshold, a latched alarm is raised. The sticky bits drive each tile's `DR_fault` input; `alarm` goes to the fabric top level.

## Interface
- `NUM_IO`, 8, number of monitored IO tiles (1..32)
- `CNT_W`, 8, width of fault event counter
- `THRESH`, 3, event count that triggers alarm (1..2^CNT_W-1)
- `WINDOW`, 64, cycles without new event before PENDING expires (1..65535)

Ports:
- `UserCLK`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `F_ctrl`  in  NUM_IO  per-tile dual-rail check (1 = invalid codeword while driving)
- `prech2`  in  1  phase signal: 0 = precharge (spacer), 1 = evaluate
- `clr`  in  1  synchronous clear of all fault state (level, sampled each edge)
- `DR_fault`  out  NUM_IO  sticky per-tile fault flags, bit i to tile i
- `fault_cnt`  out  CNT_W  qualified event count in current window, saturating
- `alarm`  out  1  high while FSM in ALARM
- `state`  out  2  FSM state: 0 MONITOR, 1 PENDING, 2 ALARM

## Operation
- Input stage: `f_reg <= F_ctrl`, `p1 <= prech2`, `p2 <= p1` every edge.
- Qualifier: `valid = p1 & p2`. The first evaluate cycle after precharge is discarded because the spacer (0,0) reads as a fault.
- `hits = f_reg & {NUM_IO{valid}}`; `event = |hits`.
- Sticky flags: `DR_fault <= DR_fault | hits`. Bits are cleared only by `clr` or reset.
- Counter: `fault_cnt` increments by 1 per cycle with `event`, regardless of how many bits are set. It saturates at 2^CNT_W-1 with no wrap.
- Window timer (16 bit):
  - loads 0 on each `event`;
  - increments in PENDING while no event;
  - reaching WINDOW-1 with no event is a timeout.
- FSM transitions:
  - MONITOR:
    - `event` and `fault_cnt+1 >= THRESH` -> ALARM (covers THRESH=1);
    - else `event` -> PENDING.
  - PENDING:
    - `event` and `fault_cnt+1 >= THRESH` -> ALARM;
    - timeout -> MONITOR, with `fault_cnt` <= 0. `DR_fault` is kept.
  - ALARM: stays until `clr`. Events still update `DR_fault` and `fault_cnt`, with saturation.
- `clr` = 1 on any state: next edge gives MONITOR, `fault_cnt`=0, `DR_fault`=0, timer=0.
  - `clr` and `event` in the same cycle: `clr` wins and the event is dropped entirely.
  - `clr` held high keeps all state cleared.
- Reset: `rst`=0 immediately forces every register to 0, regardless of clock. This gives `DR_fault`=0, `fault_cnt`=0, `alarm`=0, `state`=MONITOR, and clears `f_reg`, `p1`, `p2` and the timer. Reset mid-window discards the count.

## Timing
- Latency:
  - `F_ctrl` set before edge n is captured in `f_reg` at edge n.
  - `DR_fault`, `fault_cnt` and `state` update at edge n+1.
- `alarm` rises at the same edge on which `fault_cnt` reaches THRESH (edge n+1). No extra cycle is added.
- `prech2` must be high before edges k-1 and k for the sample in cycle k to qualify. Minimum usable evaluate phase is 2 cycles.
- Timeout:
  - For the last event at edge e (PENDING entered or stayed), the state returns to MONITOR at edge e+WINDOW.
  - An event at exactly that edge takes priority over the timeout: the count advances and the timer reloads.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/phase gating:
  - Stimulus: release `rst`, hold `prech2`=0 and `F_ctrl`=8'hFF for 10 cycles.
  - Required: `DR_fault`=0, `fault_cnt`=0, `state`=0, `alarm`=0.
- First-evaluate discard:
  - Stimulus: toggle `prech2` 0->1 with `F_ctrl`=8'h01 for exactly 1 cycle, then 0.
  - Required: no event. With `F_ctrl`=8'h01 held over 2 cycles of `prech2`=1: `DR_fault`=8'h01, `fault_cnt`=1, `state`=PENDING, 2 edges after the 2nd sample.
- Threshold:
  - Stimulus: THRESH=3; 3 isolated qualified events on bits 0, 3, 7 within 20 cycles.
  - Required: `DR_fault`=8'h89, `fault_cnt`=3, `alarm`=1 on the edge of the 3rd count.
- Window expiry:
  - Stimulus: WINDOW=64; 1 event, then none.
  - Required: `state` returns to MONITOR and `fault_cnt`=0 exactly 64 edges after the event edge; `DR_fault` is retained.
- Clear priority:
  - Stimulus: in ALARM, assert `clr` in the same cycle as a qualified event on bit 2.
  - Required: next edge gives `state`=MONITOR, `DR_fault`=0, `fault_cnt`=0, `alarm`=0.
- Saturation / async reset:
  - Stimulus: CNT_W=2, THRESH=3; 6 events.
  - Required: `fault_cnt` holds 3 (no wrap).
  - Stimulus: pulse `rst` low between edges.
  - Required: all outputs are 0 before the next edge.
